bus_tenure_arbiter: RTL and testbench

Four-requester round-robin bus arbiter with bounded tenure and a guaranteed dead cycle between owners. It sits in front of the shared bus that the round-robin grant logic already serves. It adds a tenure limit so that no requester holds the bus indefinitely, and a registered handover gap so that consecutive owners never overlap. Grants are one-hot and registered. An encoded owner ID and status flags are provided for bus muxing and monitoring.

---
 rtl/bus_tenure_arbiter_if.sv | 16 +
 rtl/bus_tenure_arbiter.sv | 90 +++++++++
 tb/tb_bus_tenure_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bus_tenure_arbiter_if.sv
// bus_tenure_if: request/grant bundle between four bus requesters and the tenure arbiter.
interface bus_tenure_if;
   logic       req0, req1, req2, req3;
   logic       gnt0, gnt1, gnt2, gnt3;
   logic [1:0] gnt_id;
   logic       busy;
   logic       expire;
   modport slave (
      input  req0, req1, req2, req3,
      output gnt0, gnt1, gnt2, gnt3, gnt_id, busy, expire
   );
   modport master (
      output req0, req1, req2, req3,
      input  gnt0, gnt1, gnt2, gnt3, gnt_id, busy, expire
   );
endinterface

// File: rtl/bus_tenure_arbiter.sv
// bus_tenure_arbiter: four-way round-robin bus arbiter with bounded tenure and a
// registered all-grants-low gap between owners; rst is asynchronous active-low.
module bus_tenure_arbiter #(
   parameter int MAX_TENURE = 16,
   parameter int GAP_CYCLES = 1
) (
   input logic         clk,
   input logic         rst,
   bus_tenure_if.slave bus
);
   localparam int TW = $clog2(MAX_TENURE + 1);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t        r_state, w_state_n;
   logic [TW-1:0] r_tenure, w_tenure_n;
   logic [3:0]    r_gap, w_gap_n;
   logic [1:0]    r_ptr, w_ptr_n, r_gnt_id, w_gnt_id_n, w_win;
   logic [3:0]    r_gnt, w_gnt_n, w_req;
   logic          r_busy, r_expire, w_expire_n, w_any, w_gap_done, w_own_req;
   assign w_req      = {bus.req3, bus.req2, bus.req1, bus.req0};
   assign w_any      = |w_req;
   assign w_gap_done = r_gap == 4'(GAP_CYCLES);
   assign w_own_req  = w_req[r_gnt_id];
   // descending scan: the nearest requester after the last owner wins, the owner itself ranks last
   always_comb begin
      w_win = r_ptr;
      for (int k = 4; k >= 1; k--)
         if (w_req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
   end
   always_comb begin
      w_state_n  = r_state;
      w_tenure_n = r_tenure;
      w_gap_n    = r_gap;
      w_ptr_n    = r_ptr;
      w_gnt_n    = r_gnt;
      w_gnt_id_n = r_gnt_id;
      w_expire_n = 1'b0;
      case (r_state)
         IDLE, GAP:
            if (r_state == IDLE || w_gap_done) begin
               if (w_any) begin
                  w_state_n  = GRANT;
                  w_gnt_n    = 4'b0001 << w_win;
                  w_gnt_id_n = w_win;
                  w_ptr_n    = w_win;
                  w_tenure_n = TW'(1);
               end else begin
                  w_state_n = IDLE;
                  w_gap_n   = 4'd0;
               end
            end else begin
               w_gap_n = r_gap + 4'd1;
            end
         GRANT:
            if (!w_own_req || r_tenure == TW'(MAX_TENURE)) begin
               w_state_n  = GAP;
               w_gnt_n    = 4'b0000;
               w_gap_n    = 4'd1;
               w_expire_n = w_own_req;
            end else begin
               w_tenure_n = r_tenure + TW'(1);
            end
         default: w_state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_tenure <= '0;
         r_gap    <= 4'd0;
         r_ptr    <= 2'd3;
         r_gnt    <= 4'b0000;
         r_gnt_id <= 2'd0;
         r_busy   <= 1'b0;
         r_expire <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_tenure <= w_tenure_n;
         r_gap    <= w_gap_n;
         r_ptr    <= w_ptr_n;
         r_gnt    <= w_gnt_n;
         r_gnt_id <= w_gnt_id_n;
         r_busy   <= w_state_n == GRANT;
         r_expire <= w_expire_n;
      end
   end
   assign {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0} = r_gnt;
   assign bus.gnt_id = r_gnt_id;
   assign bus.busy   = r_busy;
   assign bus.expire = r_expire;
endmodule

// File: tb/tb_bus_tenure_arbiter.sv
// tb_bus_tenure_arbiter: directed checks of grant order, tenure expiry, gap and reset
// on three arbiter instances (default, MAX_TENURE=4/GAP=2, MAX_TENURE=3/GAP=1).
module tb_bus_tenure_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] q0 = 4'h0, q1 = 4'h0, q2 = 4'h0;
   logic [3:0] g0, g1, g2;
   int         n_pass = 0, n_total = 0;
   bus_tenure_if b0 ();
   bus_tenure_if b1 ();
   bus_tenure_if b2 ();
   assign {b0.req3, b0.req2, b0.req1, b0.req0} = q0;
   assign {b1.req3, b1.req2, b1.req1, b1.req0} = q1;
   assign {b2.req3, b2.req2, b2.req1, b2.req0} = q2;
   assign g0 = {b0.gnt3, b0.gnt2, b0.gnt1, b0.gnt0};
   assign g1 = {b1.gnt3, b1.gnt2, b1.gnt1, b1.gnt0};
   assign g2 = {b2.gnt3, b2.gnt2, b2.gnt1, b2.gnt0};
   bus_tenure_arbiter u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   bus_tenure_arbiter #(.MAX_TENURE(4), .GAP_CYCLES(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   bus_tenure_arbiter #(.MAX_TENURE(3), .GAP_CYCLES(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // packs gnt[3:0], gnt_id, busy, expire of one instance
   function automatic logic [7:0] st(input logic [3:0] g, input logic [1:0] id, input logic b, input logic e);
      return {g, id, b, e};
   endfunction
   initial begin
      q0 = 4'hF;
      step();
      step();
      chk("reset_u0", st(g0, b0.gnt_id, b0.busy, b0.expire), 8'h00);
      chk("reset_u1", st(g1, b1.gnt_id, b1.busy, b1.expire), 8'h00);
      chk("reset_u2", st(g2, b2.gnt_id, b2.busy, b2.expire), 8'h00);
      rst = 1'b1;
      step();
      chk("first_grant", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0001, 2'd0, 1'b1, 1'b0));
      q0 = 4'h0;
      step();
      chk("first_release", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0000, 2'd0, 1'b0, 1'b0));
      step();
      chk("idle_after_gap", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0000, 2'd0, 1'b0, 1'b0));
      q0 = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("simple_gnt2_c%0d", i), st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0100, 2'd2, 1'b1, 1'b0));
      end
      q0 = 4'h0;
      step();
      chk("simple_gap", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0000, 2'd2, 1'b0, 1'b0));
      step();
      chk("simple_idle", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0000, 2'd2, 1'b0, 1'b0));
      q0 = 4'b0001;
      step();
      chk("rot_gnt0", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0001, 2'd0, 1'b1, 1'b0));
      q0 = 4'b1010;
      step();
      chk("rot_gap1", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0000, 2'd0, 1'b0, 1'b0));
      step();
      chk("rot_gnt1", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0010, 2'd1, 1'b1, 1'b0));
      step();
      chk("rot_no_preempt", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0010, 2'd1, 1'b1, 1'b0));
      q0 = 4'b1000;
      step();
      chk("rot_gap2", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0000, 2'd1, 1'b0, 1'b0));
      step();
      chk("rot_gnt3", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b1000, 2'd3, 1'b1, 1'b0));
      q0 = 4'h0;
      step();
      step();
      q0 = 4'b0100;
      step();
      chk("mid_gnt2_c1", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0100, 2'd2, 1'b1, 1'b0));
      step();
      chk("mid_gnt2_c2", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0100, 2'd2, 1'b1, 1'b0));
      #2 rst = 1'b0;
      #1;
      chk("mid_async_clear", st(g0, b0.gnt_id, b0.busy, b0.expire), 8'h00);
      q0 = 4'b1100;
      step();
      chk("mid_held", st(g0, b0.gnt_id, b0.busy, b0.expire), 8'h00);
      rst = 1'b1;
      step();
      chk("mid_regrant_gnt2", st(g0, b0.gnt_id, b0.busy, b0.expire), st(4'b0100, 2'd2, 1'b1, 1'b0));
      q0 = 4'h0;
      step();
      step();
      q1 = 4'b0010;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("exp_gnt1_r%0d_c%0d", r, i), st(g1, b1.gnt_id, b1.busy, b1.expire), st(4'b0010, 2'd1, 1'b1, 1'b0));
         end
         step();
         chk($sformatf("exp_pulse_r%0d", r), st(g1, b1.gnt_id, b1.busy, b1.expire), st(4'b0000, 2'd1, 1'b0, 1'b1));
         step();
         chk($sformatf("exp_gap2_r%0d", r), st(g1, b1.gnt_id, b1.busy, b1.expire), st(4'b0000, 2'd1, 1'b0, 1'b0));
      end
      step();
      chk("exp_regrant", st(g1, b1.gnt_id, b1.busy, b1.expire), st(4'b0010, 2'd1, 1'b1, 1'b0));
      q1 = 4'h0;
      step();
      chk("exp_normal_release", st(g1, b1.gnt_id, b1.busy, b1.expire), st(4'b0000, 2'd1, 1'b0, 1'b0));
      step();
      step();
      chk("exp_idle", st(g1, b1.gnt_id, b1.busy, b1.expire), st(4'b0000, 2'd1, 1'b0, 1'b0));
      q2 = 4'hF;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fair_o%0d_c%0d", k, i), st(g2, b2.gnt_id, b2.busy, b2.expire),
                st(4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0));
         end
         step();
         chk($sformatf("fair_gap%0d", k), st(g2, b2.gnt_id, b2.busy, b2.expire),
             st(4'b0000, 2'(k % 4), 1'b0, 1'b1));
      end
      q2 = 4'h0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
